// File: rtl/ysyx_23060180_pkg.sv
// Shared encodings, default address map and window helper for the memory responder.
package ysyx_23060180_pkg;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;

    localparam logic [31:0] DEF_BASE        = 32'h8000_0000;
    localparam logic [31:0] DEF_SERIAL_ADDR = 32'hA000_03F8;
    localparam logic [31:0] DEF_RTC_ADDR    = 32'hA000_0048;

    // True when base <= addr < base + size (33-bit math so the window may end at 2^32).
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [32:0] size);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < ({1'b0, base} + size));
    endfunction

endpackage

// File: rtl/ysyx_23060180_sync_fifo.sv
// Single-clock FIFO; a push on a full FIFO is accepted only if a pop happens in the same cycle.
module ysyx_23060180_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Synthesizable memory responder: byte RAM with registered reads, optional serial/RTC MMIO.
// Define YSYX_23060180_MEM_MMIO_EN to build the serial FIFO and the 64-bit cycle timer.
module ysyx_23060180_mem_resp
    import ysyx_23060180_pkg::*;
#(
    parameter logic [31:0] BASE        = DEF_BASE,
    parameter int unsigned DEPTH_BYTES = 65536,
    parameter logic [31:0] SERIAL_ADDR = DEF_SERIAL_ADDR,
    parameter logic [31:0] RTC_ADDR    = DEF_RTC_ADDR,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wbit_en,
    output logic [31:0] mem_rdata,
    output logic [7:0]  serial_data,
    output logic        serial_valid,
    input  logic        serial_ready,
    output logic        serial_ovf,
    output logic        bus_err
);
    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [32:0] RAM_SIZE = 33'(DEPTH_BYTES);

    logic [7:0]    ram [DEPTH_BYTES];
    logic          ram_hit;
    logic          size_ok;
    logic [3:0]    byte_we;
    logic [AW-1:0] byte_idx [4];
    logic [31:0]   ram_rdata;
    logic          mmio_hit;
    logic [31:0]   mmio_rdata;
    logic          err_now;

    // RAM decode: per-byte write enables and read bytes with same-cycle write forwarding.
    always_comb begin
        logic [31:0] a;
        ram_hit   = in_window(mem_raddr, BASE, RAM_SIZE);
        size_ok   = (mem_wbit_en == SZ_B) || (mem_wbit_en == SZ_H) || (mem_wbit_en == SZ_W);
        byte_we   = '0;
        ram_rdata = '0;
        a         = '0;
        for (int i = 0; i < 4; i++) begin
            a           = mem_raddr + 32'(i);
            byte_idx[i] = AW'(a - BASE);
            if (ram_hit && in_window(a, BASE, RAM_SIZE)) begin
                byte_we[i] = mem_wr && size_ok && (3'(i) < mem_wbit_en[2:0]);
                ram_rdata[8*i +: 8] = byte_we[i] ? mem_wdata[8*i +: 8] : ram[byte_idx[i]];
            end
        end
    end

    // RAM byte writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) ram[byte_idx[i]] <= mem_wdata[8*i +: 8];
        end
    end

`ifdef YSYX_23060180_MEM_MMIO_EN
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RTC_HI_ADDR = RTC_ADDR + 32'd4;

    logic          ser_hit;
    logic          rtc_lo_hit;
    logic          rtc_hi_hit;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [63:0]   rtc_q;
    logic [31:0]   rtc_snap_q;

    assign ser_hit      = (mem_raddr == SERIAL_ADDR);
    assign rtc_lo_hit   = (mem_raddr == RTC_ADDR);
    assign rtc_hi_hit   = (mem_raddr == RTC_HI_ADDR);
    assign mmio_hit     = ser_hit || rtc_lo_hit || rtc_hi_hit;
    assign fifo_push    = mem_wr && size_ok && ser_hit;
    assign fifo_pop     = serial_valid && serial_ready;
    assign serial_valid = !fifo_empty;
    assign serial_data  = fifo_empty ? 8'h00 : fifo_head;

    // MMIO read mux.
    always_comb begin
        mmio_rdata = '0;
        if (ser_hit)         mmio_rdata = {24'h0, 8'(fifo_count)};
        else if (rtc_lo_hit) mmio_rdata = rtc_q[31:0];
        else if (rtc_hi_hit) mmio_rdata = rtc_snap_q;
    end

    ysyx_23060180_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_serial_fifo (
        .clk     (clk),
        .rstn_in (rstn_in),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (mem_wdata[7:0]),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Cycle timer, high-word snapshot on low-word read, and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            rtc_q      <= '0;
            rtc_snap_q <= '0;
            serial_ovf <= 1'b0;
        end else begin
            rtc_q <= rtc_q + 64'd1;
            if (mem_rd && rtc_lo_hit) rtc_snap_q <= rtc_q[63:32];
            if (fifo_push && fifo_full && !fifo_pop) serial_ovf <= 1'b1;
        end
    end
`else
    logic unused_serial_ready;

    assign unused_serial_ready = serial_ready;
    assign mmio_hit            = 1'b0;
    assign mmio_rdata          = '0;
    assign serial_data         = 8'h00;
    assign serial_valid        = 1'b0;
    assign serial_ovf          = 1'b0;
`endif

    assign err_now = (mem_rd && !ram_hit && !mmio_hit) ||
                     (mem_wr && ((!ram_hit && !mmio_hit) || !size_ok));

    // Registered read data and sticky bus error.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            mem_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (mem_rd)  mem_rdata <= ram_hit ? ram_rdata : mmio_rdata;
            if (err_now) bus_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
// Directed self-checking bench for ysyx_23060180_mem_resp (RAM path, errors, optional MMIO).
module tb_ysyx_23060180_mem_resp;
    import ysyx_23060180_pkg::*;

    localparam logic [31:0] B    = 32'h8000_0000;
    localparam logic [31:0] SER  = 32'hA000_03F8;
    localparam logic [31:0] RTCL = 32'hA000_0048;
    localparam logic [31:0] RTCH = 32'hA000_004C;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_raddr, mem_wdata;
    logic [3:0]  mem_wbit_en;
    logic [31:0] mem_rdata;
    logic [7:0]  serial_data;
    logic        serial_valid, serial_ready, serial_ovf, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_23060180_mem_resp dut (
        .clk          (clk),
        .rstn_in      (rstn_in),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_raddr    (mem_raddr),
        .mem_wdata    (mem_wdata),
        .mem_wbit_en  (mem_wbit_en),
        .mem_rdata    (mem_rdata),
        .serial_data  (serial_data),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .serial_ovf   (serial_ovf),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    // One bus cycle; outputs are sampled 1 time unit after the edge that captured the request.
    task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
        mem_rd = rd; mem_wr = wr; mem_raddr = addr; mem_wdata = wdata; mem_wbit_en = be;
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic do_reset();
        rstn_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_raddr = '0;
        mem_wdata = '0; mem_wbit_en = '0; serial_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata); end
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        n_tests++; if (serial_valid !== 1'b0) begin n_fail++; $display("FAIL reset_serial_valid: got %b want 0", serial_valid); end
        n_tests++; if (serial_data !== 8'h00) begin n_fail++; $display("FAIL reset_serial_data: got %h want 00", serial_data); end
        n_tests++; if (serial_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_serial_ovf: got %b want 0", serial_ovf); end
    endtask

    task automatic test_word();
        bus(1'b0, 1'b1, B + 32'd4, 32'h0000_0000, SZ_W);
        bus(1'b0, 1'b1, B, 32'hDEAD_BEEF, SZ_W);
        bus(1'b1, 1'b0, B + 32'd1, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h00DE_ADBE) begin n_fail++; $display("FAIL word_unaligned_rd: got %h want 00deadbe", mem_rdata); end
        bus(1'b1, 1'b0, B, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_aligned_rd: got %h want deadbeef", mem_rdata); end
        bus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_tests++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_hold: got %h want deadbeef", mem_rdata); end
    endtask

    task automatic test_sub_word();
        bus(1'b0, 1'b1, B + 32'd3, 32'hFFFF_FF12, SZ_B);
        bus(1'b1, 1'b0, B, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h12AD_BEEF) begin n_fail++; $display("FAIL byte_write: got %h want 12adbeef", mem_rdata); end
        bus(1'b0, 1'b1, B + 32'd4, 32'h5555_CAFE, SZ_H);
        bus(1'b1, 1'b0, B + 32'd4, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL half_write: got %h want 0000cafe", mem_rdata); end
    endtask

    task automatic test_same_cycle();
        bus(1'b0, 1'b1, B + 32'd8, 32'h1111_1111, SZ_W);
        bus(1'b1, 1'b1, B + 32'd8, 32'h12AD_BEEF, SZ_W);
        n_tests++; if (mem_rdata !== 32'h12AD_BEEF) begin n_fail++; $display("FAIL same_cycle_word: got %h want 12adbeef", mem_rdata); end
        bus(1'b1, 1'b1, B + 32'd8, 32'h0000_0077, SZ_B);
        n_tests++; if (mem_rdata !== 32'h12AD_BE77) begin n_fail++; $display("FAIL same_cycle_byte: got %h want 12adbe77", mem_rdata); end
    endtask

    task automatic test_ram_end();
        bus(1'b0, 1'b1, B + 32'd65534, 32'hAABB_CCDD, SZ_W);
        bus(1'b1, 1'b0, B + 32'd65534, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0000_CCDD) begin n_fail++; $display("FAIL ram_end_rd: got %h want 0000ccdd", mem_rdata); end
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ram_end_no_err: got %b want 0", bus_err); end
    endtask

    task automatic test_bus_err();
        bus(1'b1, 1'b0, 32'h0000_1000, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 00000000", mem_rdata); end
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", bus_err); end
        bus(1'b0, 1'b1, B, 32'hFFFF_FFFF, 4'd3);
        bus(1'b1, 1'b0, B, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h12AD_BEEF) begin n_fail++; $display("FAIL illegal_size_dropped: got %h want 12adbeef", mem_rdata); end
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL illegal_size_err: got %b want 1", bus_err); end
    endtask

`ifdef YSYX_23060180_MEM_MMIO_EN
    task automatic test_serial();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus(1'b0, 1'b1, SER, 32'(8'h41 + k), SZ_B);
            if (k == 0) begin
                n_tests++; if (serial_valid !== 1'b1) begin n_fail++; $display("FAIL serial_valid_after_push: got %b want 1", serial_valid); end
            end
        end
        bus(1'b1, 1'b0, SER, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'd8) begin n_fail++; $display("FAIL serial_count_full: got %h want 00000008", mem_rdata); end
        n_tests++; if (serial_ovf !== 1'b1) begin n_fail++; $display("FAIL serial_ovf: got %b want 1", serial_ovf); end
        n_tests++; if (serial_data !== 8'h41) begin n_fail++; $display("FAIL serial_head: got %h want 41", serial_data); end
        serial_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (serial_valid !== 1'b1 || serial_data !== 8'(8'h41 + k)) begin
                n_fail++; $display("FAIL serial_drain_%0d: got v=%b d=%h want v=1 d=%h", k, serial_valid, serial_data, 8'(8'h41 + k));
            end
            @(posedge clk); #1;
        end
        serial_ready = 1'b0;
        n_tests++; if (serial_valid !== 1'b0) begin n_fail++; $display("FAIL serial_empty: got %b want 0", serial_valid); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int k = 0; k < 8; k++) bus(1'b0, 1'b1, SER, 32'(8'h60 + k), SZ_B);
        serial_ready = 1'b1;
        bus(1'b0, 1'b1, SER, 32'h68, SZ_B);
        serial_ready = 1'b0;
        n_tests++; if (serial_ovf !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_ovf: got %b want 0", serial_ovf); end
        n_tests++; if (serial_data !== 8'h61) begin n_fail++; $display("FAIL full_push_pop_head: got %h want 61", serial_data); end
        bus(1'b1, 1'b0, SER, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'd8) begin n_fail++; $display("FAIL full_push_pop_count: got %h want 00000008", mem_rdata); end
    endtask

    task automatic test_rtc();
        do_reset();
        bus(1'b1, 1'b0, RTCH, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rtc_snap_reset: got %h want 00000000", mem_rdata); end
        repeat (100) @(posedge clk);
        #1;
        bus(1'b1, 1'b0, RTCL, 32'h0, SZ_W);
        n_tests++; if (mem_rdata < 32'd100 || mem_rdata > 32'd120) begin n_fail++; $display("FAIL rtc_low: got %0d want 100..120", mem_rdata); end
        bus(1'b1, 1'b0, RTCH, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rtc_high: got %h want 00000000", mem_rdata); end
        bus(1'b0, 1'b1, RTCL, 32'h1234_5678, SZ_W);
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rtc_write_no_err: got %b want 0", bus_err); end
    endtask
`else
    task automatic test_mmio_off();
        do_reset();
        bus(1'b0, 1'b1, SER, 32'h41, SZ_B);
        n_tests++; if (serial_valid !== 1'b0) begin n_fail++; $display("FAIL off_serial_valid: got %b want 0", serial_valid); end
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL off_serial_err: got %b want 1", bus_err); end
        do_reset();
        bus(1'b1, 1'b0, B, 32'h0, SZ_W);
        bus(1'b1, 1'b0, RTCL, 32'h0, SZ_W);
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL off_rtc_rd: got %h want 00000000", mem_rdata); end
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL off_rtc_err: got %b want 1", bus_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_sub_word();
        test_same_cycle();
        test_ram_end();
        test_bus_err();
`ifdef YSYX_23060180_MEM_MMIO_EN
        test_serial();
        test_push_pop_full();
        test_rtc();
`else
        test_mmio_off();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_resp.md
# ysyx_23060180_mem_resp

Memory-side responder for the CPU core's single-port memory interface (`mem_rd`/`mem_wr`/`mem_raddr`/`mem_rdata`/`mem_wdata`/`mem_wbit_en`). It holds a byte-addressed backing RAM with a fixed one-cycle registered read latency and byte-count-encoded writes. It optionally decodes an MMIO window with a buffered serial-out port and a 64-bit cycle timer. It sits beside the core at top level and replaces the DPI memory model for synthesizable runs.

## Interface
Parameters:
- `BASE`, 32'h8000_0000, first RAM byte address.
- `DEPTH_BYTES`, 65536, RAM size in bytes (power of two).
- `SERIAL_ADDR`, 32'hA000_03F8, serial data/status register.
- `RTC_ADDR`, 32'hA000_0048, timer low word; `RTC_ADDR+4` is the high word.
- `FIFO_DEPTH`, 8, serial FIFO entries (power of two).

Ports:
- `clk`, in, 1, single clock; all state on posedge.
- `rstn_in`, in, 1, asynchronous active-low reset.
- `mem_rd`, in, 1, read request for the current cycle.
- `mem_wr`, in, 1, write request for the current cycle.
- `mem_raddr`, in, 32, byte address, shared by read and write.
- `mem_wdata`, in, 32, write data; the low bytes are used.
- `mem_wbit_en`, in, 4, write size: 1 = byte, 2 = half, 4 = word; other values are illegal.
- `mem_rdata`, out, 32, registered read data.
- `serial_data`, out, 8, FIFO head byte.
- `serial_valid`, out, 1, FIFO not empty.
- `serial_ready`, in, 1, sink accepts the head byte.
- `serial_ovf`, out, 1, sticky flag: a push was dropped on a full FIFO.
- `bus_err`, out, 1, sticky flag: an out-of-range access or an illegal size.

## Operation
- **RAM hit:** `BASE <= addr < BASE+DEPTH_BYTES`.
- **Reads:** return the four consecutive bytes starting at `addr`, little-endian, so `mem_rdata[7:0]` is the byte at `addr`. There is no alignment requirement. Bytes beyond the RAM end read as 0.
- **Writes:** store `mem_wbit_en` low bytes of `mem_wdata` at `addr..addr+n-1`. Bytes past the RAM end are dropped without error.
- **Out-of-range or illegal access:** an out-of-range read returns 32'h0. An out-of-range write, or `mem_wr` with an illegal `mem_wbit_en`, is dropped. Either case sets `bus_err`, which only reset clears.
- **Read and write in the same cycle:** the write commits first, and the read returns the post-write bytes.
- **No request:** `mem_rdata` holds its last value.
- **Serial (with the macro):**
  - A write to `SERIAL_ADDR` pushes `mem_wdata[7:0]`.
  - A push while full is dropped and sets `serial_ovf`. A push and a pop in the same cycle while full both succeed.
  - A read of `SERIAL_ADDR` returns `{24'h0, count}`.
  - The head byte pops on `serial_valid && serial_ready`.
- **RTC (with the macro):**
  - A 64-bit counter increments every cycle from 0 after reset.
  - A read of `RTC_ADDR` returns the low word and latches the high word into a snapshot register. A read of `RTC_ADDR+4` returns that snapshot.
  - RTC writes are ignored and raise no error.

## Timing
- **Read latency:** a read sampled at posedge N drives `mem_rdata` from posedge N+1 (available to the core's `mem_rd_d1` capture).
- **Write commit:** writes commit at the posedge where `mem_wr` is sampled high.
- **Serial output:** a push at edge N gives `serial_valid` high from edge N+1. Throughput is one pop per cycle.
- **Reset values:**
  - `mem_rdata` = 0, `serial_valid` = 0, `serial_data` = 0.
  - `serial_ovf` = 0, `bus_err` = 0.
  - FIFO pointers = 0, RTC = 0, snapshot = 0.
  - RAM contents are not reset.
- **Reset mid-operation:** pending reads and the FIFO contents are discarded. There is no sequence to complete.

## Configuration
- `YSYX_23060180_MEM_MMIO_EN` defined: the serial FIFO and RTC are decoded as above.
- Undefined:
  - `SERIAL_ADDR` and `RTC_ADDR` are ordinary out-of-range addresses: reads return 0 and set `bus_err`.
  - `serial_valid`, `serial_data` and `serial_ovf` are tied 0, and `serial_ready` is ignored.
  - No timer logic is built.

## Structure
- **Shared package `ysyx_23060180_pkg`:**
  - Size encodings `SZ_B=4'd1`, `SZ_H=4'd2`, `SZ_W=4'd4`.
  - Default `BASE`, `SERIAL_ADDR` and `RTC_ADDR` constants.
  - Address-window helper function.
- **Sub-module `ysyx_23060180_sync_fifo`:** parameterized width and depth, push/pop/full/empty/count. It is instantiated only under the macro.

## Test plan
- Word write 32'hDEADBEEF @0x80000000, then read @0x80000001 → `mem_rdata`=32'h00DEADBE on the cycle after the request.
- `sb` 0x12 @0x80000003 over prior 32'hDEADBEEF, then read @0x80000000 → 32'h12ADBEEF. The same-cycle read and write case returns 32'h12ADBEEF.
- Read @0x00001000 → `mem_rdata`=0, `bus_err`=1 one cycle later. `mem_wr` with `mem_wbit_en`=3 → no RAM change, `bus_err` stays 1.
- Macro on, `serial_ready`=0: push 9 bytes 0x41..0x49 → `count`=8, `serial_ovf`=1, `serial_data`=0x41. Raise ready → 0x41..0x48 in order, then `serial_valid`=0.
- Macro on: idle 100 cycles after reset, read `RTC_ADDR` → low word ≥100. Next read of `RTC_ADDR+4` → 0.
- Macro off: write to `SERIAL_ADDR` → `serial_valid` stays 0 and `bus_err`=1.
